// File: rtl/sipo_pkg.sv
// Shared definitions for the serial-in/parallel-out deserialiser.
// Contents: holding-register FSM state encoding and the bit-counter width helper.
// Used by: sipo_shift_core, sipo_deser.
package sipo_pkg;

    // Holding-register occupancy. The encoding doubles as out_valid.
    typedef enum logic {
        HOLD_EMPTY = 1'b0,
        HOLD_FULL  = 1'b1
    } hold_state_t;

    // Bit-counter width for a given word width. The counter must reach
    // WIDTH-1, so $clog2 is sufficient. It is clamped to 1 so the counter
    // never collapses to zero width.
    function automatic int cnt_width(input int width);
        int w;
        w = $clog2(width);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage : sipo_pkg

// File: rtl/sipo_shift_core.sv
// Shift register plus bit counter that frames a serial stream into WIDTH-bit words.
// Latency: word_done/word_dat are combinational for the edge that samples the last bit.
// Backpressure: none; this block always shifts when shift_en=1. Dropping is decided upstream.
//
// Ports:
//   clk, rst_n   clock, async active-low reset (already release-synchronised)
//   clear        synchronous flush of sreg and bit_count
//   serial_in    data bit, used only when shift_en=1
//   shift_en     shift qualifier
//   bit_count    bits collected in the current partial word
//   word_done    this edge samples the WIDTH-th bit of a word
//   word_dat     value sreg takes on this edge, i.e. the completed word when word_done=1
module sipo_shift_core
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             serial_in,
    input  logic             shift_en,
    output logic [CNT_W-1:0] bit_count,
    output logic             word_done,
    output logic [WIDTH-1:0] word_dat
);

    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    // Direction of travel through the shift register.
    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            // The first bit enters at the top and ends up in bit 0.
            assign shifted = {serial_in, sreg[WIDTH-1:1]};
        end else begin : g_msb_first
            // The first bit enters at the bottom and ends up in bit WIDTH-1.
            assign shifted = {sreg[WIDTH-2:0], serial_in};
        end
    endgenerate

    assign last_bit  = (bit_count == CNT_W'(WIDTH - 1));
    assign word_done = shift_en & last_bit;
    // The completed word includes the bit sampled on this edge, so the
    // shifted value goes out directly rather than the registered sreg.
    assign word_dat  = shifted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (clear) begin
            sreg      <= '0;
            bit_count <= '0;
        end else if (shift_en) begin
            sreg      <= shifted;
            bit_count <= last_bit ? '0 : bit_count + CNT_W'(1);
        end
    end

endmodule : sipo_shift_core

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserialiser with a one-word holding register and a valid/ready output.
// Latency: parallel_out/out_valid update on the edge that samples the WIDTH-th bit.
// Backpressure: a word that completes while the register is full and out_ready=0 is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, rst_n    clock, async active-low reset (release synchronised internally)
//   clear         synchronous flush of frame, holding register and overflow
//   serial_in     serial data bit, sampled when shift_en=1
//   shift_en      qualifies serial_in
//   out_ready     consumer takes parallel_out this cycle
//   parallel_out  assembled word, stable while out_valid=1
//   out_valid     holding register has an unconsumed word
//   bit_count     bits collected in the current partial word
//   overflow      sticky: a completed word was dropped
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 0,
    parameter int CNT_W     = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             serial_in,
    input  logic             shift_en,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] bit_count,
    output logic             overflow
);

    // ------------------------------------------------------------------
    // Reset conditioning: assertion is immediate, and release is aligned
    // to clk through two flops. The edge that releases reset never shifts.
    // ------------------------------------------------------------------
    logic rst_meta;
    logic rst_int_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta  <= 1'b0;
            rst_int_n <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_int_n <= rst_meta;
        end
    end

    // ------------------------------------------------------------------
    // Framing
    // ------------------------------------------------------------------
    logic             word_done;
    logic [WIDTH-1:0] word_dat;

    sipo_shift_core #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST),
        .CNT_W     (CNT_W)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_int_n),
        .clear     (clear),
        .serial_in (serial_in),
        .shift_en  (shift_en),
        .bit_count (bit_count),
        .word_done (word_done),
        .word_dat  (word_dat)
    );

    // ------------------------------------------------------------------
    // Holding-register FSM
    // ------------------------------------------------------------------
    hold_state_t state_q;
    hold_state_t state_d;
    logic        load;
    logic        drop;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        unique case (state_q)
            HOLD_EMPTY: begin
                // out_ready has no meaning with nothing held.
                if (word_done) begin
                    load    = 1'b1;
                    state_d = HOLD_FULL;
                end
            end
            HOLD_FULL: begin
                if (word_done) begin
                    // The consumer taking the old word on this edge frees the
                    // slot for the new one. Otherwise the new word has nowhere to go.
                    if (out_ready) begin
                        load = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end else if (out_ready) begin
                    state_d = HOLD_EMPTY;
                end
            end
            default: begin
                state_d = HOLD_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= HOLD_EMPTY;
        end else if (clear) begin
            state_q <= HOLD_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // parallel_out keeps its last value after consumption and changes only on load.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            parallel_out <= '0;
        end else if (clear) begin
            parallel_out <= '0;
        end else if (load) begin
            parallel_out <= word_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end
    end

    assign out_valid = (state_q == HOLD_FULL);

endmodule : sipo_deser

// File: tb/tb_sipo_deser.sv
module tb_sipo_deser;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       serial_in;
    logic       shift_en;
    logic       out_ready;

    logic [7:0] po_m,  po_l;
    logic       vld_m, vld_l;
    logic [2:0] cnt_m, cnt_l;
    logic       ovf_m, ovf_l;

    int nvec = 0;
    int nerr = 0;

    sipo_deser #(.WIDTH(8), .LSB_FIRST(0)) u_msb (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .out_ready    (out_ready),
        .parallel_out (po_m),
        .out_valid    (vld_m),
        .bit_count    (cnt_m),
        .overflow     (ovf_m)
    );

    sipo_deser #(.WIDTH(8), .LSB_FIRST(1)) u_lsb (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (clear),
        .serial_in    (serial_in),
        .shift_en     (shift_en),
        .out_ready    (out_ready),
        .parallel_out (po_l),
        .out_valid    (vld_l),
        .bit_count    (cnt_l),
        .overflow     (ovf_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       clr;
        logic       sen;
        logic       sin;
        logic       rdy;
        logic [7:0] po;
        logic       vld;
        logic [2:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add_row(input logic clr_i, input logic sen_i, input logic sin_i,
                           input logic rdy_i, input logic [7:0] po_i, input logic vld_i,
                           input logic [2:0] cnt_i, input logic ovf_i);
        vec_t v;
        v.clr = clr_i; v.sen = sen_i; v.sin = sin_i; v.rdy = rdy_i;
        v.po  = po_i;  v.vld = vld_i; v.cnt = cnt_i; v.ovf = ovf_i;
        vq.push_back(v);
    endtask

    // Eight MSB-first bit rows of one byte. Outputs hold their "before"
    // values for bits 1..7 and take their "after" values on bit 8.
    task automatic add_byte(input logic [7:0] b, input logic rdy, input logic rdy_last,
                            input logic [7:0] po_b, input logic vld_b, input logic ovf_b,
                            input logic [7:0] po_a, input logic vld_a, input logic ovf_a);
        for (int i = 0; i < 7; i++) begin
            add_row(1'b0, 1'b1, b[7-i], rdy, po_b, vld_b, 3'(i + 1), ovf_b);
        end
        add_row(1'b0, 1'b1, b[0], rdy_last, po_a, vld_a, 3'd0, ovf_a);
    endtask

    // Apply inputs, then sample 1 time unit after the edge that consumes them.
    task automatic drive(input logic clr_i, input logic sen_i, input logic sin_i, input logic rdy_i);
        clear     = clr_i;
        shift_en  = sen_i;
        serial_in = sin_i;
        out_ready = rdy_i;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm,
                       input logic [7:0] po_a, input logic vld_a, input logic [2:0] cnt_a, input logic ovf_a,
                       input logic [7:0] po_e, input logic vld_e, input logic [2:0] cnt_e, input logic ovf_e);
        nvec++;
        if ({po_a, vld_a, cnt_a, ovf_a} !== {po_e, vld_e, cnt_e, ovf_e}) begin
            nerr++;
            $display("FAIL %s: got po=%h vld=%b cnt=%0d ovf=%b, expected po=%h vld=%b cnt=%0d ovf=%b",
                     nm, po_a, vld_a, cnt_a, ovf_a, po_e, vld_e, cnt_e, ovf_e);
        end
    endtask

    initial begin
        logic [7:0] s2;
        logic [7:0] c3;

        rst_n = 1'b0; clear = 1'b0; serial_in = 1'b0; shift_en = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_msb", po_m, vld_m, cnt_m, ovf_m, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("reset_lsb", po_l, vld_l, cnt_l, ovf_l, 8'h00, 1'b0, 3'd0, 1'b0);
        #3 rst_n = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("post_release", po_m, vld_m, cnt_m, ovf_m, 8'h00, 1'b0, 3'd0, 1'b0);

        // Continuous stream, consumer always ready: B2, then a one-cycle valid pulse.
        add_byte(8'hB2, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 8'hB2, 1'b1, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 3'd0, 1'b0);
        // Backpressure: A5 held, 3C dropped, overflow sticks after consumption.
        add_byte(8'hA5, 1'b0, 1'b0, 8'hB2, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0);
        add_byte(8'h3C, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 3'd0, 1'b1);
        // Consume and complete on the same edge: 22 replaces 11 without overflow.
        add_row(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        add_byte(8'h11, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0);
        add_byte(8'h22, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 8'h22, 1'b1, 1'b0);
        add_row(1'b0, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 3'd0, 1'b0);
        // Clear mid-frame while full and overflowed, then F0 starts from bit 0.
        add_byte(8'h77, 1'b0, 1'b0, 8'h22, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0);
        add_byte(8'h55, 1'b0, 1'b0, 8'h77, 1'b1, 1'b0, 8'h77, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            add_row(1'b0, 1'b1, 1'b1, 1'b0, 8'h77, 1'b1, 3'(i + 1), 1'b1);
        end
        add_row(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0);
        add_byte(8'hF0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'hF0, 1'b1, 1'b0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].clr, vq[i].sen, vq[i].sin, vq[i].rdy);
            chk($sformatf("vec%0d", i), po_m, vld_m, cnt_m, ovf_m,
                vq[i].po, vq[i].vld, vq[i].cnt, vq[i].ovf);
        end

        // LSB-first: 1,0,1,1,0,0,1,0 assembles to 4D.
        s2 = 8'b1011_0010;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        chk("lsb_clear", po_l, vld_l, cnt_l, ovf_l, 8'h00, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, s2[7-i], 1'b1);
            if (i < 7) begin
                chk($sformatf("lsb_bit%0d", i), po_l, vld_l, cnt_l, ovf_l, 8'h00, 1'b0, 3'(i + 1), 1'b0);
            end
        end
        chk("lsb_word", po_l, vld_l, cnt_l, ovf_l, 8'h4D, 1'b1, 3'd0, 1'b0);
        // Same stream with a 3-cycle shift_en gap after bit 4.
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, s2[7-i], 1'b1);
        end
        chk("lsb_pre_gap", po_l, vld_l, cnt_l, ovf_l, 8'h4D, 1'b0, 3'd4, 1'b0);
        for (int g = 0; g < 3; g++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1);
            chk($sformatf("lsb_gap%0d", g), po_l, vld_l, cnt_l, ovf_l, 8'h4D, 1'b0, 3'd4, 1'b0);
        end
        for (int i = 4; i < 8; i++) begin
            drive(1'b0, 1'b1, s2[7-i], 1'b1);
        end
        chk("lsb_gap_word", po_l, vld_l, cnt_l, ovf_l, 8'h4D, 1'b1, 3'd0, 1'b0);

        // Asynchronous reset mid-frame, then a clean C3.
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1);
        end
        chk("pre_rst", po_m, vld_m, cnt_m, ovf_m, 8'h00, 1'b0, 3'd5, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_msb", po_m, vld_m, cnt_m, ovf_m, 8'h00, 1'b0, 3'd0, 1'b0);
        chk("async_rst_lsb", po_l, vld_l, cnt_l, ovf_l, 8'h00, 1'b0, 3'd0, 1'b0);
        #2 rst_n = 1'b1;
        repeat (4) drive(1'b0, 1'b0, 1'b0, 1'b1);
        c3 = 8'hC3;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, c3[7-i], 1'b1);
            if (i == 6) begin
                chk("c3_bit7", po_m, vld_m, cnt_m, ovf_m, 8'h00, 1'b0, 3'd7, 1'b0);
            end
        end
        chk("c3_word", po_m, vld_m, cnt_m, ovf_m, 8'hC3, 1'b1, 3'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule : tb_sipo_deser
